// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store stage.
//   mem_op_e  - memory operation encodings carried on mem_op
//   state_e   - load/store stage FSM states
//   is_load / is_store / access_size - operation classification helpers
package lsu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LD   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_LHU  = 4'd6,
        MEM_LWU  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SD   = 4'd11
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_WB
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LD,
            MEM_LBU, MEM_LHU, MEM_LWU: is_load = 1'b1;
            default:                   is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW, MEM_SD: is_store = 1'b1;
            default:                        is_store = 1'b0;
        endcase
    endfunction

    // 0 = byte, 1 = half, 2 = word, 3 = double; non-memory ops report 0
    function automatic logic [1:0] access_size(input logic [3:0] op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: access_size = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: access_size = 2'd2;
            MEM_LD, MEM_SD:          access_size = 2'd3;
            default:                 access_size = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_load_align.sv
// load_align: selects the addressed bytes from an aligned 64-bit load beat
// and sign/zero-extends them according to the load type.
//   rdata - aligned 64-bit load data from memory
//   off   - byte offset of the access within the beat
//   op    - load operation (mem_op encoding)
//   data  - extended result for write-back
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data    = '0;
        case (op)
            MEM_LB:  data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            MEM_LH:  data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_LW:  data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MEM_LBU: data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            MEM_LHU: data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            MEM_LWU: data = {{(XLEN-32){1'b0}},        shifted[31:0]};
            // doubles are always aligned, so the shift is zero here
            MEM_LD:  data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage following the ALU.
//   in_*        - ALU result handshake (accepted only in IDLE)
//   mem_req_*   - aligned 64-bit memory request (valid/ready)
//   mem_rsp_*   - load data return (valid-only pulse)
//   wb_*        - write-back record to the register file (valid/ready)
//   misalign    - qualifies wb_valid: faulting access, no memory traffic
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [RD_W-1:0] rd_addr,
    input  logic [3:0]      mem_op,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_wen,
    output logic            misalign
);

    state_e          state_q;
    logic [3:0]      op_q;
    logic [2:0]      off_q;
    logic            in_ready_q;
    logic            req_valid_q;
    logic [XLEN-1:0] req_addr_q;
    logic            req_wen_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [7:0]      req_wmask_q;
    logic            wb_valid_q;
    logic [XLEN-1:0] wb_data_q;
    logic [RD_W-1:0] wb_rd_q;
    logic            wb_wen_q;
    logic            misalign_q;

    logic [2:0]      off_d;
    logic [1:0]      size_d;
    logic            misalign_d;
    logic [7:0]      wmask_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] load_data;

    assign off_d  = alu_result[2:0];
    assign size_d = access_size(mem_op);

    always_comb begin
        misalign_d = 1'b0;
        wmask_d    = 8'hFF;
        case (size_d)
            2'd0: begin misalign_d = 1'b0;          wmask_d = 8'h01 << off_d; end
            2'd1: begin misalign_d = off_d[0];      wmask_d = 8'h03 << off_d; end
            2'd2: begin misalign_d = |off_d[1:0];   wmask_d = 8'h0F << off_d; end
            default: begin misalign_d = |off_d;     wmask_d = 8'hFF;          end
        endcase
    end

    assign wdata_d = store_data << {off_d, 3'b000};

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata (mem_rsp_rdata),
        .off   (off_q),
        .op    (op_q),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_wen_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= mem_op;
                        off_q      <= off_d;
                        wb_rd_q    <= rd_addr;
                        in_ready_q <= 1'b0;
                        if (!is_load(mem_op) && !is_store(mem_op)) begin
                            state_q    <= S_WB;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= alu_result;
                            wb_wen_q   <= (rd_addr != '0);
                        end else if (misalign_d) begin
                            state_q    <= S_WB;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= alu_result;
                            wb_wen_q   <= 1'b0;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= {alu_result[XLEN-1:3], 3'b000};
                            req_wen_q   <= is_store(mem_op);
                            req_wdata_q <= wdata_d;
                            req_wmask_q <= wmask_d;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (is_store(op_q)) begin
                            state_q    <= S_WB;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            wb_wen_q   <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_RSP;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state_q    <= S_WB;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_data;
                        wb_wen_q   <= (wb_rd_q != '0);
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b0;
                        wb_wen_q   <= 1'b0;
                        misalign_q <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_wen        = wb_wen_q;
    assign misalign      = misalign_q;

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage directly downstream of the ALU in the NPC core.
- Consumes the ALU result as an effective address (memory ops) or as a pass-through value (all other ops).
- Issues one aligned 64-bit memory transaction over a valid/ready request and valid-only response interface.
- Aligns/extends load data and presents a single write-back record to the register-file stage.

Parameters:
XLEN, 64, datapath and address width
RD_W, 5, destination register index width

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept (high only in IDLE)
alu_result  input  XLEN  effective address or pass-through value
store_data  input  XLEN  rs2 value for stores
rd_addr  input  RD_W  destination register
mem_op  input  4  0 NONE,1 LB,2 LH,3 LW,4 LD,5 LBU,6 LHU,7 LWU,8 SB,9 SH,10 SW,11 SD,12-15 treated as NONE
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  address with low 3 bits forced to 0
mem_req_wen  output  1  1 = store
mem_req_wdata  output  XLEN  store data shifted to byte lane
mem_req_wmask  output  8  byte enables
mem_rsp_valid  input  1  load data valid (one-cycle pulse)
mem_rsp_rdata  input  XLEN  aligned 64-bit load data
wb_valid  output  1  write-back record valid
wb_ready  input  1  write-back consumer accepts
wb_data  output  XLEN  result value
wb_rd  output  RD_W  destination register
wb_wen  output  1  register write enable
misalign  output  1  qualifies wb_valid: access was misaligned, no memory access made

Behaviour:
- Reset value of all outputs is 0, except in_ready, which is 1 (state IDLE). Captured registers clear to 0.
- FSM states: IDLE, REQ, WAIT_RSP, WB.
- IDLE:
  - in_ready=1. On in_valid, capture all inputs.
  - NONE → WB, with wb_data=alu_result. Latency is 1 cycle.
  - Misaligned access (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0) → WB with misalign=1, wb_wen=0, wb_data=alu_result (the fault address).
  - Any other memory op → REQ.
- REQ:
  - mem_req_valid=1. Address, wdata, wmask and wen are registered and held stable until mem_req_ready.
  - On handshake: store → WB with wb_wen=0; load → WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid, capture load_align(rdata, addr[2:0], op) into wb_data → WB.
  - Minimum load latency is 3 cycles (accept, req, rsp) plus memory wait.
- WB:
  - wb_valid=1; record held stable until wb_ready, then → IDLE.
  - There is no IDLE bypass: the next in_valid is accepted the cycle after the WB handshake.
- wb_wen=1 only for completed loads and NONE, and only when rd≠0.
- Store lanes:
  - SB: wmask = 1<<off; SH: 3<<off; SW: 0xF<<off; SD: 0xFF.
  - wdata = store_data << (8*off), where off = addr[2:0].
- Load extend:
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
- mem_rsp_valid outside WAIT_RSP is ignored, including a response in the same cycle as request acceptance.
- rst in any state → IDLE next cycle. Outstanding requests are abandoned; a later stale response lands in IDLE and is ignored.
- in_valid while not in IDLE: the input is not consumed. The upstream stage holds it.

Decomposition:
- Package lsu_pkg: mem_op encodings; the state enum; helpers is_load, is_store, and access_size (0=B, 1=H, 2=W, 3=D).
- Sub-module load_align: combinational; inputs rdata, off, op; outputs the extended 64-bit value.
  - The byte-lane shift and mask generation stay inline in lsu_stage.

Test Plan:
- NONE, alu_result=0x1234, rd=5, wb_ready=1 → wb_valid the cycle after accept; wb_data=0x1234, wb_wen=1, no mem_req_valid.
- LB addr=0x80000003, rdata=0x0000_0000_8000_0000 (byte 3=0x80) → wb_data=0xFFFF_FFFF_FFFF_FF80, wb_wen=1, mem_req_addr=0x80000000. Repeat with LBU → 0x80.
- SH addr=0x80000006, store_data=0xBEEF, mem_req_ready delayed 3 cycles → req fields stable 4 cycles; wmask=0xC0, wdata=0xBEEF_0000_0000_0000; wb_valid with wb_wen=0.
- LW addr=0x80000002 → misalign=1, wb_data=0x80000002, wb_wen=0, no mem_req_valid ever.
- LD with rd=0, wb_ready low 5 cycles → wb_valid held, in_ready=0 throughout, wb_wen=0; next op accepted the cycle after the handshake.
- rst asserted in WAIT_RSP, then mem_rsp_valid 2 cycles later → state IDLE, wb_valid never asserts, in_ready=1.
